// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial two's-complement add/sub, DIGIT bits per clock, LSB first (saturation via SERIAL_ADDSUB_SAT_EN)
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cb,
  output logic             ovf,
  output logic             zero
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  if (WIDTH < 2 || WIDTH % DIGIT != 0) begin : g_param_check
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d, raw, fin;
  logic carry_q, carry_d, sub_q, sub_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic cb_q, cb_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [DIGIT:0] sum;
  logic load, run, last, ovf_w;
  always_comb begin
    load = start && state_q != RUN;
    run = state_q == RUN;
    last = run && cnt_q == LAST;
    sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    raw = WIDTH'({sum[DIGIT-1:0], acc_q} >> DIGIT);
    ovf_w = (a_msb_q == b_msb_q) && (raw[WIDTH-1] != a_msb_q);
`ifdef SERIAL_ADDSUB_SAT_EN
    fin = ovf_w ? {a_msb_q, {(WIDTH-1){~a_msb_q}}} : raw;
`else
    fin = raw;
`endif
    state_d = load ? RUN : last ? DONE : state_q == DONE ? IDLE : state_q;
    cnt_d = load ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    a_d = load ? a : run ? a_q >> DIGIT : a_q;
    b_d = load ? (sub ? ~b : b) : run ? b_q >> DIGIT : b_q;
    carry_d = load ? sub : run ? sum[DIGIT] : carry_q;
    sub_d = load ? sub : sub_q;
    a_msb_d = load ? a[WIDTH-1] : a_msb_q;
    b_msb_d = load ? (sub ? ~b[WIDTH-1] : b[WIDTH-1]) : b_msb_q;
    acc_d = run ? raw : acc_q;
    // visible outputs only change on the final digit edge; acc_q does the shifting
    result_d = last ? fin : result_q;
    cb_d = last ? (sub_q ? ~sum[DIGIT] : sum[DIGIT]) : cb_q;
    ovf_d = last ? ovf_w : ovf_q;
    zero_d = last ? fin == '0 : zero_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      carry_q <= 1'b0;
      sub_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      result_q <= '0;
      cb_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      carry_q <= carry_d;
      sub_q <= sub_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      result_q <= result_d;
      cb_q <= cb_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign result = result_q;
  assign cb = cb_q;
  assign ovf = ovf_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench over three WIDTH=8 instances (DIGIT=1,4,2); honours SERIAL_ADDSUB_SAT_EN
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic start_i [3];
  logic sub_i [3];
  logic [7:0] a_i [3];
  logic [7:0] b_i [3];
  logic busy_o [3];
  logic done_o [3];
  logic cb_o [3];
  logic ovf_o [3];
  logic zero_o [3];
  logic [7:0] res_o [3];
  int errors = 0;
  int checks = 0;
  int n_of [3] = '{8, 2, 4};
  typedef struct packed {logic [7:0] r; logic cb; logic ovf; logic z;} exp_t;
  exp_t sb [$];

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (.clk(clk), .rst(rst), .start(start_i[0]), .sub(sub_i[0]),
    .a(a_i[0]), .b(b_i[0]), .busy(busy_o[0]), .done(done_o[0]), .result(res_o[0]), .cb(cb_o[0]),
    .ovf(ovf_o[0]), .zero(zero_o[0]));
  serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d4 (.clk(clk), .rst(rst), .start(start_i[1]), .sub(sub_i[1]),
    .a(a_i[1]), .b(b_i[1]), .busy(busy_o[1]), .done(done_o[1]), .result(res_o[1]), .cb(cb_o[1]),
    .ovf(ovf_o[1]), .zero(zero_o[1]));
  serial_addsub #(.WIDTH(8), .DIGIT(2)) u_d2 (.clk(clk), .rst(rst), .start(start_i[2]), .sub(sub_i[2]),
    .a(a_i[2]), .b(b_i[2]), .busy(busy_o[2]), .done(done_o[2]), .result(res_o[2]), .cb(cb_o[2]),
    .ovf(ovf_o[2]), .zero(zero_o[2]));

  // integer-arithmetic reference: unsigned for result/carry/borrow, signed range for overflow
  function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic s);
    exp_t e;
    int ua, ub, sa, sbv, u, sv;
    ua = a;
    ub = b;
    sa = $signed(a);
    sbv = $signed(b);
    u = s ? ua - ub : ua + ub;
    sv = s ? sa - sbv : sa + sbv;
    e.r = u[7:0];
    e.cb = s ? (ua < ub) : (u > 255);
    e.ovf = sv > 127 || sv < -128;
`ifdef SERIAL_ADDSUB_SAT_EN
    if (sv > 127) e.r = 8'h7F;
    if (sv < -128) e.r = 8'h80;
`endif
    e.z = e.r == 8'h00;
    return e;
  endfunction

  task automatic launch(int idx, logic [7:0] a, logic [7:0] b, logic s);
    a_i[idx] = a;
    b_i[idx] = b;
    sub_i[idx] = s;
    start_i[idx] = 1'b1;
    sb.push_back(model(a, b, s));
    @(posedge clk);
    #1 start_i[idx] = 1'b0;
  endtask

  task automatic finish_op(int idx, int cyc0, string name);
    int cyc, busy_n;
    logic [7:0] held;
    bit hold_ok;
    exp_t e;
    cyc = cyc0;
    busy_n = cyc0 - 1;
    held = res_o[idx];
    hold_ok = 1;
    while (done_o[idx] !== 1'b1 && cyc <= 40) begin
      if (busy_o[idx] === 1'b1) busy_n++;
      if (res_o[idx] !== held) hold_ok = 0;
      @(posedge clk);
      #1 cyc++;
    end
    checks++;
    if (cyc != n_of[idx] + 1) begin
      errors++;
      $display("FAIL %s latency: done in cycle %0d, expected %0d", name, cyc, n_of[idx] + 1);
    end
    checks++;
    if (busy_n != n_of[idx]) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d, expected %0d", name, busy_n, n_of[idx]);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL %s result_hold: result changed during RUN (was %h, now %h)", name, held, res_o[idx]);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: no expected entry", name);
    end else begin
      e = sb.pop_front();
      if ({res_o[idx], cb_o[idx], ovf_o[idx], zero_o[idx]} !== e) begin
        errors++;
        $display("FAIL %s outputs: result=%h cb=%b ovf=%b zero=%b, expected result=%h cb=%b ovf=%b zero=%b",
                 name, res_o[idx], cb_o[idx], ovf_o[idx], zero_o[idx], e.r, e.cb, e.ovf, e.z);
      end
    end
  endtask

  task automatic run_op(int idx, logic [7:0] a, logic [7:0] b, logic s, string name);
    launch(idx, a, b, s);
    finish_op(idx, 1, name);
    @(posedge clk);
    #1 checks++;
    if (done_o[idx] !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: done=%b one cycle later, expected 0", name, done_o[idx]);
    end
  endtask

  task automatic check_cleared(int idx, string name);
    checks++;
    if ({busy_o[idx], done_o[idx], res_o[idx], cb_o[idx], ovf_o[idx], zero_o[idx]} !== 13'd0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b result=%h cb=%b ovf=%b zero=%b, expected all 0", name,
               busy_o[idx], done_o[idx], res_o[idx], cb_o[idx], ovf_o[idx], zero_o[idx]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_cleared(i, "reset_state");
    rst = 1'b0;
  endtask

  task automatic test_digit1();
    run_op(0, 8'h05, 8'h03, 1'b1, "d1_5_minus_3");
    run_op(0, 8'h03, 8'h05, 1'b1, "d1_3_minus_5");
    run_op(0, 8'h7F, 8'h7F, 1'b1, "d1_7f_minus_7f");
  endtask

  task automatic test_digit4();
    run_op(1, 8'h7F, 8'h01, 1'b0, "d4_7f_plus_1");
    run_op(1, 8'h80, 8'h80, 1'b0, "d4_80_plus_80");
  endtask

  task automatic test_digit2();
    run_op(2, 8'h80, 8'h01, 1'b1, "d2_80_minus_1");
    run_op(2, 8'hFF, 8'h01, 1'b0, "d2_ff_plus_1");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < 3; i++)
        run_op(i, 8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)), "random");
  endtask

  task automatic test_ignore_start();
    launch(0, 8'h12, 8'h34, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    start_i[0] = 1'b1;
    a_i[0] = 8'hAA;
    b_i[0] = 8'h55;
    sub_i[0] = 1'b1;
    @(posedge clk);
    #1;
    start_i[0] = 1'b0;
    a_i[0] = 8'h00;
    b_i[0] = 8'h00;
    finish_op(0, 4, "ignore_start");
    @(posedge clk);
    #1 checks++;
    if (busy_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start idle: busy=%b after done, expected 0", busy_o[0]);
    end
  endtask

  task automatic test_back_to_back();
    launch(2, 8'h10, 8'h20, 1'b0);
    finish_op(2, 1, "b2b_first");
    launch(2, 8'h50, 8'h30, 1'b1);
    finish_op(2, 1, "b2b_second");
    launch(0, 8'h44, 8'h22, 1'b1);
    finish_op(0, 1, "b2b_d1_first");
    launch(0, 8'h40, 8'h11, 1'b0);
    finish_op(0, 1, "b2b_d1_second");
    @(posedge clk);
    #1 checks++;
    if (done_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b done_pulse: done=%b, expected 0", done_o[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    launch(0, 8'h40, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_cleared(0, "reset_mid");
    if (sb.size() > 0) void'(sb.pop_front());
    saw_done = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (done_o[0] === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL reset_mid no_done: done=1 seen after abort, expected none");
    end
    run_op(0, 8'h22, 8'h11, 1'b1, "after_reset");
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_i[i] = 1'b0;
      sub_i[i] = 1'b0;
      a_i[i] = 8'h00;
      b_i[i] = 8'h00;
    end
    test_reset();
    test_digit1();
    test_digit4();
    test_digit2();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
